// File: rtl/mesi_pkg.sv
// Shared bus-op and controller-state encodings for the snooping bus
// controller and the MESI cache controllers that attach to it.
package mesi_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    BUS_WB   = 3'b000,
    BUS_RD   = 3'b001,
    BUS_RDX  = 3'b010,
    BUS_UPGR = 3'b011
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNOOP  = 3'd1,
    ST_RESP   = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_WB     = 3'd5,
    ST_DONE   = 3'd6
  } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester after 'last' (wrapping) wins.
module rr_arbiter
  import mesi_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [N-1:0]    grant
);

  logic [IDXW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDXW'((int'(last) + k) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller: arbitrates cache requests, broadcasts snoops,
// and resolves each transaction by cache-to-cache flush or memory access.
module snoop_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CACHES-1:0]            req,
  input  logic [OP_W*NUM_CACHES-1:0]       op,
  input  logic [ADDR_WIDTH*NUM_CACHES-1:0] addr,
  input  logic [LINE_BITS*NUM_CACHES-1:0]  wb_data,
  input  logic [NUM_CACHES-1:0]            snoop_hit,
  input  logic [NUM_CACHES-1:0]            snoop_dirty,
  output logic [NUM_CACHES-1:0]            grant,
  output logic [OP_W-1:0]                  snoop_op,
  output logic [ADDR_WIDTH-1:0]            snoop_addr,
  output logic [LINE_BITS-1:0]             data_out,
  output logic [NUM_CACHES-1:0]            data_ready,
  output logic                             shared,
  output logic                             proto_err,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_BITS-1:0]             mem_wdata,
  input  logic [LINE_BITS-1:0]             mem_rdata,
  input  logic                             mem_ack
);

  localparam int IDXW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int OFFS = $clog2(LINE_BITS / 8);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

  bus_state_e            state_q, state_d;
  logic [IDXW-1:0]       win_q, last_q;
  bus_op_e               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  shared_q;
  logic [LINE_BITS-1:0]  data_q;
  logic                  proto_err_q;

  logic [OP_W-1:0]       op_arr   [NUM_CACHES];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CACHES];
  logic [LINE_BITS-1:0]  line_arr [NUM_CACHES];

  logic [NUM_CACHES-1:0] arb_grant;
  logic [IDXW-1:0]       arb_idx;
  logic [NUM_CACHES-1:0] win_oh;
  logic [NUM_CACHES-1:0] hit_m, dirty_m;
  logic [IDXW-1:0]       sup_idx;
  logic                  multi_dirty;

  genvar g;
  generate
    for (g = 0; g < NUM_CACHES; g++) begin : g_unpack
      assign op_arr[g]   = op[g*OP_W +: OP_W];
      assign addr_arr[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign line_arr[g] = wb_data[g*LINE_BITS +: LINE_BITS];
    end
  endgenerate

  rr_arbiter #(
    .N    (NUM_CACHES),
    .IDXW (IDXW)
  ) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    win_oh  = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (arb_grant[i]) arb_idx = IDXW'(i);
      win_oh[i] = (win_q == IDXW'(i));
    end
  end

  // The requester's own snoop response is ignored; the lowest dirty peer supplies.
  assign hit_m       = snoop_hit & ~win_oh;
  assign dirty_m     = snoop_dirty & ~win_oh;
  assign multi_dirty = |(dirty_m & (dirty_m - NUM_CACHES'(1)));

  always_comb begin
    sup_idx = '0;
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (dirty_m[i]) sup_idx = IDXW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      last_q      <= IDXW'(NUM_CACHES - 1);
      op_q        <= BUS_WB;
      addr_q      <= '0;
      shared_q    <= 1'b0;
      data_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            win_q    <= arb_idx;
            op_q     <= bus_op_e'(op_arr[arb_idx]);
            addr_q   <= addr_arr[arb_idx];
            shared_q <= 1'b0;
          end
        end
        ST_RESP: begin
          shared_q <= |hit_m;
          if (multi_dirty) proto_err_q <= 1'b1;
          if (op_q != BUS_UPGR && |dirty_m) data_q <= line_arr[sup_idx];
        end
        ST_MEM_RD: begin
          if (mem_ack) data_q <= mem_rdata;
        end
        ST_DONE: last_q <= win_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = (op_arr[arb_idx] == BUS_WB) ? ST_WB : ST_SNOOP;
      end
      ST_SNOOP: state_d = ST_RESP;
      ST_RESP: begin
        if (op_q == BUS_UPGR)  state_d = ST_DONE;
        else if (|dirty_m)     state_d = ST_FLUSH;
        else                   state_d = ST_MEM_RD;
      end
      ST_MEM_RD, ST_FLUSH, ST_WB: begin
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state so an async reset clears them at once.
  always_comb begin
    grant      = '0;
    data_ready = '0;
    snoop_op   = '0;
    snoop_addr = '0;
    shared     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q != ST_IDLE) grant = win_oh;
    case (state_q)
      ST_SNOOP: begin
        snoop_op   = op_q;
        snoop_addr = addr_q;
      end
      ST_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q & LINE_MASK;
      end
      ST_FLUSH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q & LINE_MASK;
        mem_wdata = data_q;
      end
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q & LINE_MASK;
        mem_wdata = line_arr[win_q];
      end
      ST_DONE: begin
        data_ready = win_oh;
        shared     = shared_q;
      end
      default: ;
    endcase
  end

  assign data_out  = data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: directed transactions push expected
// completions and memory accesses; monitors pop and compare as they appear.
module tb_snoop_bus_ctrl;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LB = 256;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [3*N-1:0]  op;
  logic [AW*N-1:0] addr;
  logic [LB*N-1:0] wb_data;
  logic [N-1:0]    snoop_hit, snoop_dirty;
  logic [N-1:0]    grant, data_ready;
  logic [2:0]      snoop_op;
  logic [AW-1:0]   snoop_addr, mem_addr;
  logic [LB-1:0]   data_out, mem_wdata, mem_rdata;
  logic            shared, proto_err, mem_req, mem_we, mem_ack;

  snoop_bus_ctrl #(.NUM_CACHES(N), .ADDR_WIDTH(AW), .LINE_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wb_data(wb_data),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .grant(grant),
    .snoop_op(snoop_op), .snoop_addr(snoop_addr), .data_out(data_out),
    .data_ready(data_ready), .shared(shared), .proto_err(proto_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          chk_data;
    logic [LB-1:0] data;
    logic          shr;
  } sb_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [LB-1:0] d;
  } mx_t;

  sb_t sb_q[$];
  mx_t mx_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0, done_cyc = 0, issue_cyc = 0;
  int snoop_cnt = 0, mem_cnt = 0, mem_wait = 0, mem_lat = 3;
  logic [AW-1:0] seen_snoop_addr;
  logic [2:0]    seen_snoop_op;
  logic [LB-1:0] rdata_val;

  localparam logic [LB-1:0] LINE_A = {8{32'hA0A1A2A3}};
  localparam logic [LB-1:0] LINE_B = {8{32'hB0B1B2B3}};
  localparam logic [LB-1:0] LINE_C = {8{32'hC0C1C2C3}};
  localparam logic [LB-1:0] LINE_D = {8{32'hD0D1D2D3}};
  localparam logic [LB-1:0] LINE_E = {8{32'hE0E1E2E3}};
  localparam logic [LB-1:0] LINE_F = {8{32'hF0F1F2F3}};

  task automatic checkOutput(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every data_ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (snoop_op != 3'b000) begin
        snoop_cnt++;
        seen_snoop_op   = snoop_op;
        seen_snoop_addr = snoop_addr;
      end
      if (mem_req) mem_cnt++;
      if (data_ready != '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_ready", LB'(data_ready), '0);
        end else begin
          sb_t e;
          logic [N-1:0] oh;
          e  = sb_q.pop_front();
          oh = N'(1) << e.idx;
          checkOutput("ready_idx", LB'(data_ready), LB'(oh));
          checkOutput("grant_at_done", LB'(grant), LB'(oh));
          if (e.chk_data) checkOutput("data_out", data_out, e.data);
          checkOutput("shared", LB'(shared), LB'(e.shr));
        end
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Memory responder: acks after mem_lat request cycles and checks each access.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack  = 1'b0;
      mem_wait = 0;
    end else if (mem_req && !mem_ack) begin
      mem_wait++;
      if (mem_wait >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
        mem_wait  = 0;
        if (mx_q.size() == 0) begin
          checkOutput("unexpected_mem", LB'(mem_addr), '0);
        end else begin
          mx_t m;
          m = mx_q.pop_front();
          checkOutput("mem_we", LB'(mem_we), LB'(m.we));
          checkOutput("mem_addr", LB'(mem_addr), LB'(m.a));
          if (m.we) checkOutput("mem_wdata", mem_wdata, m.d);
        end
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) checkOutput("done_wait", LB'(done_cnt), LB'(target));
  endtask

  task automatic applyStimulus(input int idx, input logic [2:0] o, input logic [AW-1:0] a,
                               input logic chk, input logic [LB-1:0] d, input logic shr);
    sb_t e;
    int  n = 0;
    int  target;
    e.idx = idx; e.chk_data = chk; e.data = d; e.shr = shr;
    sb_q.push_back(e);
    target    = done_cnt + 1;
    snoop_cnt = 0;
    mem_cnt   = 0;
    op[idx*3 +: 3]    = o;
    addr[idx*AW +: AW] = a;
    req[idx]  = 1'b1;
    issue_cyc = cyc;
    do begin
      @(negedge clk);
      n++;
    end while (!grant[idx] && n < 20);
    if (!grant[idx]) checkOutput("grant_wait", LB'(grant), LB'(N'(1) << idx));
    req[idx] = 1'b0;
    wait_done(target, 60);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int done_before;
    rst_n = 1'b0; req = '0; op = '0; addr = '0; wb_data = '0;
    snoop_hit = '0; snoop_dirty = '0; mem_rdata = '0; mem_ack = 1'b0;
    rdata_val = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", LB'(grant), '0);
    checkOutput("rst_mem", LB'({mem_req, mem_we, mem_addr}), '0);
    checkOutput("rst_data", data_out, '0);
    checkOutput("rst_flags", LB'({data_ready, shared, proto_err, snoop_op, snoop_addr}), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] cache1 BusRd from memory");
    mem_lat = 3; rdata_val = LINE_A;
    mx_q.push_back('{we: 1'b0, a: 32'h1000, d: '0});
    applyStimulus(1, 3'b001, 32'h1000, 1'b1, LINE_A, 1'b0);
    checkOutput("rd_snoop_op", LB'(seen_snoop_op), LB'(3'b001));
    checkOutput("rd_snoop_addr", LB'(seen_snoop_addr), LB'(32'h1000));

    $display("[TB] cache0 BusRd flushed by dirty cache2");
    snoop_hit = 4'b0100; snoop_dirty = 4'b0100;
    wb_data[2*LB +: LB] = LINE_B;
    mx_q.push_back('{we: 1'b1, a: 32'h2000, d: LINE_B});
    applyStimulus(0, 3'b001, 32'h2000, 1'b1, LINE_B, 1'b1);

    $display("[TB] cache2 BusRdX ignores its own hit/dirty");
    mem_lat = 1; rdata_val = LINE_C;
    mx_q.push_back('{we: 1'b0, a: 32'h3000, d: '0});
    applyStimulus(2, 3'b010, 32'h3000, 1'b1, LINE_C, 1'b0);

    $display("[TB] cache3 BusUpgr");
    snoop_hit = 4'b0001; snoop_dirty = 4'b0000;
    applyStimulus(3, 3'b011, 32'h40, 1'b1, LINE_C, 1'b1);
    checkOutput("upgr_snoop_cycles", LB'(snoop_cnt), LB'(1));
    checkOutput("upgr_snoop_op", LB'(seen_snoop_op), LB'(3'b011));
    checkOutput("upgr_snoop_addr", LB'(seen_snoop_addr), LB'(32'h40));
    checkOutput("upgr_no_mem", LB'(mem_cnt), '0);
    checkOutput("upgr_latency", LB'(done_cyc - issue_cyc), LB'(3));

    $display("[TB] two dirty peers on cache0 BusRdX");
    checkOutput("proto_err_before", LB'(proto_err), '0);
    snoop_hit = 4'b0110; snoop_dirty = 4'b0110;
    wb_data[1*LB +: LB] = LINE_D;
    wb_data[2*LB +: LB] = LINE_E;
    mem_lat = 2;
    mx_q.push_back('{we: 1'b1, a: 32'h2040, d: LINE_D});
    applyStimulus(0, 3'b010, 32'h2040, 1'b1, LINE_D, 1'b1);
    checkOutput("proto_err_set", LB'(proto_err), LB'(1'b1));

    $display("[TB] cache2 writeback with unaligned address");
    snoop_hit = 4'b1111; snoop_dirty = 4'b0000;
    wb_data[2*LB +: LB] = LINE_F;
    mx_q.push_back('{we: 1'b1, a: 32'h5000, d: LINE_F});
    applyStimulus(2, 3'b000, 32'h5017, 1'b0, '0, 1'b0);
    checkOutput("wb_no_snoop", LB'(snoop_cnt), '0);
    checkOutput("proto_err_sticky", LB'(proto_err), LB'(1'b1));

    $display("[TB] reset during memory read");
    snoop_hit = '0; snoop_dirty = '0;
    mem_lat = 10;
    op[1*3 +: 3] = 3'b001; addr[1*AW +: AW] = 32'h7000;
    req[1] = 1'b1;
    base = 0;
    while (!mem_req && base < 20) begin
      @(negedge clk);
      base++;
    end
    checkOutput("mem_rd_started", LB'(mem_req), LB'(1'b1));
    req[1] = 1'b0;
    done_before = done_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_grant", LB'(grant), '0);
    checkOutput("abort_mem", LB'({mem_req, mem_we, mem_addr}), '0);
    checkOutput("abort_flags", LB'({data_ready, proto_err, data_out[31:0]}), '0);
    repeat (2) @(negedge clk);
    checkOutput("abort_no_ready", LB'(done_cnt), LB'(done_before));

    $display("[TB] continuous requests from all caches");
    req = 4'b1111;
    op  = {4{3'b011}};
    for (int i = 0; i < 5; i++) begin
      sb_t e;
      e.idx = i % N; e.chk_data = 1'b1; e.data = '0; e.shr = 1'b0;
      sb_q.push_back(e);
    end
    base = done_cnt + 5;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_grant_after_rst", LB'(grant), LB'(4'b0001));
    wait_done(base, 100);
    req = '0;
    repeat (6) @(negedge clk);

    checkOutput("sb_drain", LB'(sb_q.size()), '0);
    checkOutput("mem_drain", LB'(mx_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snoop_bus_ctrl.md
SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 Parameter NUM_CACHES, default 4: number of attached cache controllers.
REQ-002 Parameter ADDR_WIDTH, default 32: bus address width.
REQ-003 Parameter LINE_BITS, default 256: cache line width in bits.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_CACHES  per-cache bus request.
REQ-007 op  input  3*NUM_CACHES  per-cache op; 000 writeback, 001 BusRd, 010 BusRdX, 011 BusUpgr.
REQ-008 addr  input  ADDR_WIDTH*NUM_CACHES  per-cache request address.
REQ-009 wb_data  input  LINE_BITS*NUM_CACHES  per-cache line data for writeback or flush.
REQ-010 snoop_hit  input  NUM_CACHES  cache holds snooped line valid.
REQ-011 snoop_dirty  input  NUM_CACHES  cache holds snooped line in M.
REQ-012 grant  output  NUM_CACHES  one-hot bus ownership.
REQ-013 snoop_op  output  3  broadcast op; 000 when idle.
REQ-014 snoop_addr  output  ADDR_WIDTH  broadcast address.
REQ-015 data_out  output  LINE_BITS  fill data to requester.
REQ-016 data_ready  output  NUM_CACHES  one-cycle completion pulse to requester.
REQ-017 shared  output  1  other cache held the line; valid with data_ready.
REQ-018 proto_err  output  1  sticky: more than one snoop_dirty seen.
REQ-019 mem_req, mem_we  output  1 each  memory request, write enable.
REQ-020 mem_addr  output  ADDR_WIDTH  line-aligned memory address.
REQ-021 mem_wdata  output  LINE_BITS; mem_rdata  input  LINE_BITS; mem_ack  input  1.

Function
REQ-022 FSM states IDLE, SNOOP, RESP, MEM_RD, FLUSH, WB, DONE.
REQ-023 IDLE: if any req, select winner round-robin starting at index after last winner; latch index, op, addr; grant[winner]=1 next cycle; go SNOOP (op 000 goes WB directly).
REQ-024 grant stays asserted from arbitration through DONE inclusive; deasserted in IDLE.
REQ-025 SNOOP: snoop_op/snoop_addr driven for exactly one cycle; go RESP.
REQ-026 RESP: sample snoop_hit/snoop_dirty with requester's bit masked; shared_latched = OR of masked hits.
REQ-027 RESP, BusUpgr -> DONE, no memory access, data_out unchanged.
REQ-028 RESP, BusRd/BusRdX, any masked dirty -> FLUSH, data taken from lowest-index dirty cache's wb_data.
REQ-029 RESP, BusRd/BusRdX, no dirty -> MEM_RD.
REQ-030 MEM_RD: mem_req=1, mem_we=0 until mem_ack; capture mem_rdata into data_out; -> DONE.
REQ-031 FLUSH: mem_req=1, mem_we=1, mem_wdata=supplier line until mem_ack; data_out=supplier line; -> DONE.
REQ-032 WB: mem write of requester wb_data until mem_ack; -> DONE; shared=0.
REQ-033 DONE: data_ready[winner]=1 and shared valid for one cycle; update last-winner; -> IDLE.
REQ-034 mem_addr = latched addr with low log2(LINE_BITS/8) bits zeroed.
REQ-035 req withdrawn while granted: transaction still completes.
REQ-036 Two or more masked dirty bits in RESP: set proto_err, still use lowest index.
REQ-037 Minimum transaction: 4 cycles arbitration-to-data_ready plus memory wait.

Reset
REQ-038 All outputs 0, FSM IDLE, last-winner = NUM_CACHES-1 so cache 0 wins first.
REQ-039 Reset mid-transaction aborts it; no data_ready issued; memory request dropped.

Structure
REQ-040 Bus op encodings and FSM state encodings in shared package mesi_pkg, also used by mesi cache.
REQ-041 One sub-module rr_arbiter (req vector, last pointer -> one-hot grant).

Verification
REQ-042 Cache1 BusRd 0x1000, no hits, mem_ack after 3 cycles, rdata=A -> data_ready[1], data_out=A, shared=0.
REQ-043 Cache0 BusRd 0x2000, cache2 snoop_dirty with line B -> mem write B to 0x2000, data_out=B, shared=1.
REQ-044 Cache3 BusUpgr 0x40 -> snoop_op=011 one cycle, no mem_req, data_ready[3] 3 cycles after grant.
REQ-045 req=1111 continuously -> grants cycle 0,1,2,3,0.
REQ-046 Dirty on caches 1 and 2 for cache0 BusRdX -> proto_err=1, supplier cache1.
REQ-047 rst_n low during MEM_RD -> all outputs 0 immediately, next grant to cache 0.
